// File: rtl/cell_editor.sv
// Cursor-driven cell toggler: word read-modify-write (toggle -> we_out after READ_LATENCY+2 cycles); all moves/requests dropped while busy.
// Optional CELL_EDITOR_CLEAR_EN adds a gap-free zeroing sweep of the whole board on clear_in.
module cell_editor #(
  parameter int READ_LATENCY   = 2,
  parameter int WORD_SIZE      = 16,
  parameter int LOG_WORD_SIZE  = 4,
  parameter int BOARD_SIZE     = 64,
  parameter int LOG_BOARD_SIZE = 6,
  parameter int LOG_MAX_ADDR   = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      up_in,
  input  logic                      down_in,
  input  logic                      left_in,
  input  logic                      right_in,
  input  logic                      toggle_in,
  input  logic                      clear_in,
  input  logic [WORD_SIZE-1:0]      data_r_in,
  output logic [LOG_MAX_ADDR-1:0]   addr_r_out,
  output logic [LOG_MAX_ADDR-1:0]   addr_w_out,
  output logic [WORD_SIZE-1:0]      data_w_out,
  output logic                      we_out,
  output logic                      busy_out,
  output logic                      done_out,
  output logic [LOG_BOARD_SIZE-1:0] cursor_x_out,
  output logic [LOG_BOARD_SIZE-1:0] cursor_y_out
);

  localparam int WORDS_PER_ROW = BOARD_SIZE / WORD_SIZE;
  localparam int NUM_WORDS     = BOARD_SIZE * WORDS_PER_ROW;
  localparam logic [LOG_MAX_ADDR-1:0] LAST_ADDR = LOG_MAX_ADDR'(NUM_WORDS - 1);
  localparam logic [2:0] WAIT_LAST = 3'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CAPTURE,
    S_WRITE,
    S_CLEAR
  } state_t;

  state_t                    state_q, state_d;
  logic [2:0]                cnt_q, cnt_d;
  logic [LOG_BOARD_SIZE-1:0] cursor_x_q, cursor_x_d;
  logic [LOG_BOARD_SIZE-1:0] cursor_y_q, cursor_y_d;
  logic [LOG_MAX_ADDR-1:0]   addr_r_q, addr_r_d;
  logic [LOG_MAX_ADDR-1:0]   addr_w_q, addr_w_d;
  logic [WORD_SIZE-1:0]      data_w_q, data_w_d;
  logic [WORD_SIZE-1:0]      mask_q, mask_d;
  logic                      we_q, we_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic                      clear_req;
  logic [LOG_MAX_ADDR-1:0]   cur_addr;
  logic [LOG_WORD_SIZE-1:0]  cur_bit;
  logic [WORD_SIZE-1:0]      cur_mask;

`ifdef CELL_EDITOR_CLEAR_EN
  assign clear_req = clear_in;
`else
  logic unused_clear;
  assign unused_clear = clear_in;
  assign clear_req    = 1'b0;
`endif

  // Same cell->word/bit mapping as the renderer; leftmost cell is the word MSB.
  assign cur_addr = LOG_MAX_ADDR'(cursor_y_q) * LOG_MAX_ADDR'(WORDS_PER_ROW)
                  + LOG_MAX_ADDR'(cursor_x_q >> LOG_WORD_SIZE);
  assign cur_bit  = LOG_WORD_SIZE'(WORD_SIZE - 1) - cursor_x_q[LOG_WORD_SIZE-1:0];
  assign cur_mask = WORD_SIZE'(1) << cur_bit;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cursor_x_d = cursor_x_q;
    cursor_y_d = cursor_y_q;
    addr_r_d   = addr_r_q;
    addr_w_d   = addr_w_q;
    data_w_d   = data_w_q;
    mask_d     = mask_q;
    busy_d     = busy_q;
    we_d       = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          state_d  = S_CLEAR;
          busy_d   = 1'b1;
          we_d     = 1'b1;
          addr_w_d = '0;
          data_w_d = '0;
          done_d   = (NUM_WORDS == 1);
        end else if (toggle_in) begin
          state_d  = S_WAIT;
          busy_d   = 1'b1;
          cnt_d    = '0;
          addr_r_d = cur_addr;
          mask_d   = cur_mask;
        end else begin
          // Power-of-two board: plain modular arithmetic gives the wrap.
          if (left_in)       cursor_x_d = cursor_x_q - LOG_BOARD_SIZE'(1);
          else if (right_in) cursor_x_d = cursor_x_q + LOG_BOARD_SIZE'(1);
          if (up_in)         cursor_y_d = cursor_y_q - LOG_BOARD_SIZE'(1);
          else if (down_in)  cursor_y_d = cursor_y_q + LOG_BOARD_SIZE'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) state_d = S_CAPTURE;
        else                    cnt_d   = cnt_q + 3'd1;
      end
      S_CAPTURE: begin
        data_w_d = data_r_in ^ mask_q;
        addr_w_d = addr_r_q;
        we_d     = 1'b1;
        done_d   = 1'b1;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
`ifdef CELL_EDITOR_CLEAR_EN
      S_CLEAR: begin
        if (addr_w_q == LAST_ADDR) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          addr_w_d = addr_w_q + LOG_MAX_ADDR'(1);
          we_d     = 1'b1;
          done_d   = (addr_w_d == LAST_ADDR);
        end
      end
`endif
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cursor_x_q <= '0;
      cursor_y_q <= '0;
      addr_r_q   <= '0;
      addr_w_q   <= '0;
      data_w_q   <= '0;
      mask_q     <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cursor_x_q <= cursor_x_d;
      cursor_y_q <= cursor_y_d;
      addr_r_q   <= addr_r_d;
      addr_w_q   <= addr_w_d;
      data_w_q   <= data_w_d;
      mask_q     <= mask_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign addr_r_out   = addr_r_q;
  assign addr_w_out   = addr_w_q;
  assign data_w_out   = data_w_q;
  assign we_out       = we_q;
  assign busy_out     = busy_q;
  assign done_out     = done_q;
  assign cursor_x_out = cursor_x_q;
  assign cursor_y_out = cursor_y_q;

endmodule

// File: doc/cell_editor.md
Name: cell_editor

Overview:
- Write-side counterpart to the display read path.
- Holds a user cursor in board-cell coordinates and moves it on button pulses.
- On a toggle request, flips the addressed cell in board memory with a word-wide read-modify-write.
- Sits between the debounced button logic and the board memory write port. It shares the cell→word/bit mapping used by the renderer, so an edited cell is the one displayed at that position.

Parameters:
- READ_LATENCY, 2: cycles from addr_r_out change to valid data_r_in (BRAM with output register); legal 1..4.
- Widths and constants come from common.svh: WORD_SIZE, LOG_WORD_SIZE, BOARD_SIZE, LOG_BOARD_SIZE, LOG_MAX_ADDR.
- Derived: WORDS_PER_ROW = BOARD_SIZE/WORD_SIZE; NUM_WORDS = BOARD_SIZE*WORDS_PER_ROW.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous, active-high reset
- up_in, down_in, left_in, right_in  in  1 each  single-cycle move pulses
- toggle_in  in  1  single-cycle request to flip the cell under the cursor
- clear_in  in  1  single-cycle request to zero the board (used only with the optional feature)
- data_r_in  in  WORD_SIZE  read data from board memory
- addr_r_out  out  LOG_MAX_ADDR  read address to board memory
- addr_w_out  out  LOG_MAX_ADDR  write address
- data_w_out  out  WORD_SIZE  write data
- we_out  out  1  write enable, one cycle per word
- busy_out  out  1  high while an operation is in flight
- done_out  out  1  one-cycle pulse when an operation completes
- cursor_x_out, cursor_y_out  out  LOG_BOARD_SIZE each  cursor cell coordinates

Behaviour:
- Interface: one clock (clk_in); reset rst_in is synchronous and active-high.
- Reset: all outputs 0; cursor (0,0); state IDLE.
- Reset mid-operation aborts the operation. No we_out is issued after the reset cycle.
- All outputs are registered.
- Address mapping:
  - addr = cursor_y*WORDS_PER_ROW + (cursor_x >> LOG_WORD_SIZE), computed at full LOG_MAX_ADDR width (no precedence or truncation slip).
  - bit = WORD_SIZE-1-cursor_x[LOG_WORD_SIZE-1:0] (MSB = leftmost cell).
  - mask = 1<<bit.
- Cursor movement:
  - Moves apply only in IDLE with no toggle_in/clear_in in the same cycle.
  - Pulses arriving while busy are dropped, not queued.
  - Movement wraps modulo BOARD_SIZE in both directions: x=0 plus left gives BOARD_SIZE-1; x=BOARD_SIZE-1 plus right gives 0; y likewise.
  - up and down together: up wins. left and right together: left wins.
  - Horizontal and vertical moves in the same cycle both apply.
  - Up decrements y.
- Request priority in IDLE: clear_in > toggle_in > moves.
- FSM states:
  - IDLE: on toggle_in (cycle 0), latch addr and mask, drive addr_r_out, set busy_out; go to WAIT.
  - WAIT: count READ_LATENCY cycles (cycles 1..READ_LATENCY).
  - CAPTURE: cycle READ_LATENCY+1; register data_w_out = data_r_in ^ mask and addr_w_out = latched addr.
  - WRITE: cycle READ_LATENCY+2; we_out=1 and done_out=1 for exactly this cycle; busy_out=1. Next state IDLE with busy_out=0.
- Toggle latency: toggle_in in cycle 0 → we_out in cycle READ_LATENCY+2, i.e. cycle 4 at the default.
- addr_r_out is held stable from cycle 1 through CAPTURE.
- we_out is never high outside WRITE (or the CLEAR sweep).
- Only the single target bit may differ between read and written word.

Optional Feature:
- Macro: CELL_EDITOR_CLEAR_EN.
- Defined: clear_in in IDLE enters state CLEAR. It writes data_w_out=0 with we_out=1 to addr_w_out = 0,1,…,NUM_WORDS-1, one word per cycle with no gaps. busy_out stays high throughout. done_out pulses in the cycle with the last write; IDLE follows. Cursor is unchanged.
- Undefined: clear_in is ignored entirely; the port remains so the interface is stable.

Test Plan (BOARD_SIZE=64, WORD_SIZE=16, READ_LATENCY=2):
- Reset, then toggle at (0,0) with mem[0]=0x0000 → cycle 4: we_out=1, addr_w_out=0, data_w_out=0x8000, done_out=1; busy_out low in cycle 5.
- 17 right + 2 down pulses, then toggle with mem[9]=0xFFFF → cursor (17,2); addr_r_out=9; write 0xBFFF to address 9.
- From (0,0), one left and one up → cursor (63,63). Then right+left in the same cycle → (62,63).
- Toggle, then right pulses in cycles 1–3 → cursor unchanged after done_out; exactly one we_out.
- Toggle, then rst_in asserted in cycle 2 → no we_out, no done_out, all outputs 0, cursor (0,0).
- With CELL_EDITOR_CLEAR_EN: clear_in → 256 consecutive writes of 0 to addresses 0..255, done_out on the 256th; without the macro, clear_in → no we_out, busy_out stays 0.
